game_countdown: RTL and testbench

GAME_COUNTDOWN -- requirements
Module: game_countdown

---
 rtl/game_countdown.sv | 128 ++++++++++++
 tb/tb_game_countdown.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/game_countdown.sv
// game_countdown: M:SS BCD countdown timer for the game display.
// Counts down one second per tick while running. Supports pause, resume,
// clear and restart-after-expiry. Flags warning in the final WARN_SEC
// seconds and pulses expired once when the count reaches 0:00.
module game_countdown #(
    parameter int START_MIN = 2,   // minutes loaded on reload (0-9)
    parameter int START_SEC = 0,   // seconds loaded on reload (0-59)
    parameter int WARN_SEC  = 10   // remaining-seconds threshold for warning
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       tick,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       warning,
    output logic       time_up,
    output logic       expired
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_PAUSED  = 2'd2;
    localparam logic [1:0] S_EXPIRED = 2'd3;

    // Start value split into BCD digits once, at elaboration time.
    localparam logic [3:0] RELOAD_MIN  = 4'(START_MIN);
    localparam logic [3:0] RELOAD_TENS = 4'(START_SEC / 10);
    localparam logic [3:0] RELOAD_ONES = 4'(START_SEC % 10);
    localparam logic [9:0] WARN_LIMIT  = 10'(WARN_SEC);

    logic [1:0] state, state_nxt;
    logic [3:0] min_nxt, tens_nxt, ones_nxt;
    logic [3:0] dec_min, dec_tens, dec_ones;
    logic       expired_nxt;
    logic       at_one;
    logic       at_zero;
    logic [9:0] total;

    assign at_one  = (min_ones == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd1);
    assign at_zero = (min_ones == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd0);

    // One-second BCD decrement with borrow ripple; holds at 0:00 so the
    // digits can never wrap below zero.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
        dec_min  = min_ones;
        dec_tens = sec_tens;
        dec_ones = sec_ones;
        if (sec_ones != 4'd0) begin
            dec_ones = sec_ones - 4'd1;
        end else if (sec_tens != 4'd0) begin
            dec_tens = sec_tens - 4'd1;
            dec_ones = 4'd9;
        end else if (min_ones != 4'd0) begin
            dec_min  = min_ones - 4'd1;
            dec_tens = 4'd5;
            dec_ones = 4'd9;
        end
    end

    // Next state and digits; priority is clear, start, pause, tick.
    // A start while already running, or a pause outside RUN, has no effect
    // and leaves lower-priority inputs to act.
    always_comb begin
        state_nxt   = state;
        min_nxt     = min_ones;
        tens_nxt    = sec_tens;
        ones_nxt    = sec_ones;
        expired_nxt = 1'b0;
        if (clear) begin
            state_nxt = S_IDLE;
            min_nxt   = RELOAD_MIN;
            tens_nxt  = RELOAD_TENS;
            ones_nxt  = RELOAD_ONES;
        end else if (start && (state != S_RUN)) begin
            state_nxt = S_RUN;
            if (state == S_EXPIRED) begin
                min_nxt  = RELOAD_MIN;
                tens_nxt = RELOAD_TENS;
                ones_nxt = RELOAD_ONES;
            end
        end else if (state == S_RUN) begin
            if (pause) begin
                state_nxt = S_PAUSED;
            end else if (tick && !at_zero) begin
                min_nxt  = dec_min;
                tens_nxt = dec_tens;
                ones_nxt = dec_ones;
                if (at_one) begin
                    state_nxt   = S_EXPIRED;
                    expired_nxt = 1'b1;
                end
            end
        end
    end

    // State, digit and expiry-pulse registers with asynchronous reload on reset.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state    <= S_IDLE;
            min_ones <= RELOAD_MIN;
            sec_tens <= RELOAD_TENS;
            sec_ones <= RELOAD_ONES;
            expired  <= 1'b0;
        end else begin
            // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
            state    <= state_nxt;
            min_ones <= min_nxt;
            sec_tens <= tens_nxt;
            sec_ones <= ones_nxt;
            expired  <= expired_nxt;
        end
    end

    // Remaining time in whole seconds, used only for the warning window.
    assign total = (10'(min_ones) * 10'd60) + (10'(sec_tens) * 10'd10) + 10'(sec_ones);

    assign running = (state == S_RUN);
    assign time_up = (state == S_EXPIRED);
    assign warning = ((state == S_RUN) || (state == S_PAUSED)) &&
                     (total >= 10'd1) && (total <= WARN_LIMIT);

endmodule

// File: tb/tb_game_countdown.sv
// tb_game_countdown: three countdown instances (2:00, 1:00, 0:03) share one
// stimulus stream. A seconds-based model predicts every output each cycle;
// directed scenarios add literal expectations, then random pulses follow.
module tb_game_countdown;

    logic clk;
    logic resetN;
    logic tick, start, pause, clear;

    logic [3:0] mo [3];
    logic [3:0] st [3];
    logic [3:0] so [3];
    logic       run_o [3];
    logic       warn_o [3];
    logic       tup_o [3];
    logic       xp_o [3];

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    game_countdown #(.START_MIN(2), .START_SEC(0), .WARN_SEC(10)) u_def (
        .clk(clk), .resetN(resetN), .tick(tick), .start(start), .pause(pause), .clear(clear),
        .min_ones(mo[0]), .sec_tens(st[0]), .sec_ones(so[0]),
        .running(run_o[0]), .warning(warn_o[0]), .time_up(tup_o[0]), .expired(xp_o[0]));

    game_countdown #(.START_MIN(1), .START_SEC(0), .WARN_SEC(10)) u_one (
        .clk(clk), .resetN(resetN), .tick(tick), .start(start), .pause(pause), .clear(clear),
        .min_ones(mo[1]), .sec_tens(st[1]), .sec_ones(so[1]),
        .running(run_o[1]), .warning(warn_o[1]), .time_up(tup_o[1]), .expired(xp_o[1]));

    game_countdown #(.START_MIN(0), .START_SEC(3), .WARN_SEC(10)) u_short (
        .clk(clk), .resetN(resetN), .tick(tick), .start(start), .pause(pause), .clear(clear),
        .min_ones(mo[2]), .sec_tens(st[2]), .sec_ones(so[2]),
        .running(run_o[2]), .warning(warn_o[2]), .time_up(tup_o[2]), .expired(xp_o[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model (whole seconds) ----------------
    typedef enum logic [1:0] {M_IDLE, M_RUN, M_PAUSED, M_EXP} mode_e;
    typedef struct packed {
        mode_e mode;
        int    rem;
        bit    pulse;
    } mstate_t;

    mstate_t m_st [3];

    function automatic int start_total(int i);
        case (i)
            0:       return 120;
            1:       return 60;
            default: return 3;
        endcase
    endfunction

    function automatic mstate_t model_step(mstate_t s, int tot0, bit t, bit sp, bit p, bit c);
        mstate_t n = s;
        n.pulse = 1'b0;
        if (c) begin
            n.mode = M_IDLE;
            n.rem  = tot0;
        end else if (sp && s.mode != M_RUN) begin
            if (s.mode == M_EXP) n.rem = tot0;
            n.mode = M_RUN;
        end else if (s.mode == M_RUN) begin
            if (p) begin
                n.mode = M_PAUSED;
            end else if (t && s.rem > 0) begin
                n.rem = s.rem - 1;
                if (n.rem == 0) begin
                    n.mode  = M_EXP;
                    n.pulse = 1'b1;
                end
            end
        end
        return n;
    endfunction

    // Expected output vector {min, tens, ones, running, warning, time_up, expired}.
    function automatic logic [15:0] model_vec(mstate_t s);
        logic w;
        w = (s.mode == M_RUN || s.mode == M_PAUSED) && s.rem >= 1 && s.rem <= 10;
        return {4'(s.rem / 60), 4'((s.rem % 60) / 10), 4'(s.rem % 10),
                s.mode == M_RUN, w, s.mode == M_EXP, s.pulse};
    endfunction

    function automatic logic [15:0] dut_vec(int i);
        return {mo[i], st[i], so[i], run_o[i], warn_o[i], tup_o[i], xp_o[i]};
    endfunction

    function automatic logic [15:0] lit(int m, int t, int o, logic [3:0] flags);
        return {4'(m), 4'(t), 4'(o), flags};
    endfunction

    always @(posedge clk or negedge resetN) begin
        for (int i = 0; i < 3; i++) begin
            if (!resetN) m_st[i] <= '{M_IDLE, start_total(i), 1'b0};
            else         m_st[i] <= model_step(m_st[i], start_total(i), tick, start, pause, clear);
        end
    end

    task automatic check(string name, logic [15:0] act, logic [15:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Per-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++)
                check($sformatf("cycle_u%0d", i), dut_vec(i), model_vec(m_st[i]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse(bit t, bit sp, bit p, bit c);
        @(posedge clk); #1;
        tick = t; start = sp; pause = p; clear = c;
        @(posedge clk); #1;
        tick = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0;
    endtask

    task automatic ticks(int n);
        for (int k = 0; k < n; k++) pulse(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        resetN = 1'b0;
        tick = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("reset_def",   dut_vec(0), lit(2, 0, 0, 4'b0000));
        check("reset_one",   dut_vec(1), lit(1, 0, 0, 4'b0000));
        check("reset_short", dut_vec(2), lit(0, 0, 3, 4'b0000));
        resetN = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_wait", dut_vec(0), lit(2, 0, 0, 4'b0000));

        // start, then ticks: double borrow, 1:57, expiry of the short timer
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("start_run", dut_vec(0), lit(2, 0, 0, 4'b1000));
        ticks(1);
        check("double_borrow", dut_vec(1), lit(0, 5, 9, 4'b1000));
        ticks(2);
        check("three_ticks", dut_vec(0), lit(1, 5, 7, 4'b1000));
        check("expire_pulse", dut_vec(2), lit(0, 0, 0, 4'b0011));
        @(posedge clk); #1;
        check("expire_one_cycle", dut_vec(2), lit(0, 0, 0, 4'b0010));
        ticks(47);
        check("warn_at_10", dut_vec(1), lit(0, 1, 0, 4'b1100));
        check("expired_holds", dut_vec(2), lit(0, 0, 0, 4'b0010));

        // pause with coincident tick, ignored ticks while paused, resume
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(30);
        check("at_1_30", dut_vec(0), lit(1, 3, 0, 4'b1000));
        pulse(1'b1, 1'b0, 1'b1, 1'b0);
        check("tick_pause", dut_vec(0), lit(1, 3, 0, 4'b0000));
        ticks(5);
        check("paused_hold", dut_vec(0), lit(1, 3, 0, 4'b0000));
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(1);
        check("resume_tick", dut_vec(0), lit(1, 2, 9, 4'b1000));

        // run to expiry, restart from EXPIRED, then clear with a tick
        ticks(89);
        check("def_expired", dut_vec(0), lit(0, 0, 0, 4'b0011));
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("restart_reload", dut_vec(0), lit(2, 0, 0, 4'b1000));
        ticks(15);
        check("at_1_45", dut_vec(0), lit(1, 4, 5, 4'b1000));
        pulse(1'b1, 1'b0, 1'b0, 1'b1);
        check("clear_tick", dut_vec(0), lit(2, 0, 0, 4'b0000));

        // asynchronous reset in the middle of a run at 0:05
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(115);
        check("at_0_05", dut_vec(0), lit(0, 0, 5, 4'b1100));
        @(posedge clk); #3;
        resetN = 1'b0;
        #1;
        check("async_reset", dut_vec(0), lit(2, 0, 0, 4'b0000));
        repeat (2) @(posedge clk);
        #1;
        resetN = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_reset_idle", dut_vec(0), lit(2, 0, 0, 4'b0000));

        // randomized pulses, checked cycle by cycle against the model
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #1;
            tick   = ($urandom_range(0, 1) == 1);
            start  = ($urandom_range(0, 11) == 0);
            pause  = ($urandom_range(0, 9) == 0);
            clear  = ($urandom_range(0, 59) == 0);
            resetN = ($urandom_range(0, 399) != 0);
        end
        @(posedge clk); #1;
        tick = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0; resetN = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
